multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Multi-cycle RV32I control unit: a Moore-style FSM that sequences fetch, decode, execute, memory and writeback over several cycles.
- Drives the shared-datapath selects and enables, and waits on a single unified memory port through a req/ready handshake.
- Includes a memory-timeout watchdog and a retired-instruction counter.
- Sits between the instruction register/flags and the datapath.

Parameters:
- ALU_CTRL_W, 3, width of ALUctrl.
- CNT_W, 32, width of the retired-instruction counter.
- MEM_TIMEOUT, 15, maximum wait cycles for mem_ready; 0 disables the watchdog.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- op  in  7  instr[6:0] from the IR.
- funct3  in  3  instr[14:12].
- funct7_5  in  1  instr[30].
- Zero  in  1  ALU zero flag.
- mem_ready  in  1  memory handshake completion.
- mem_req  out  1  memory access request.
- MemWrite  out  1  store enable, qualified by mem_req.
- AdrSrc  out  1  0 = PC, 1 = ALUOut as memory address.
- IRWrite  out  1  instruction register load.
- PCWrite  out  1  PC load.
- RegWrite  out  1  register file write.
- ResultSrc  out  2  00 ALUOut, 01 memory data, 10 ALU result.
- ALUSrcA  out  2  00 PC, 01 oldPC, 10 rs1.
- ALUSrcB  out  2  00 rs2, 01 imm, 10 const 4.
- ALUctrl  out  ALU_CTRL_W  ALU operation.
- ImmSrc  out  2  00 I, 01 S, 10 B, 11 J.
- mem_err  out  1  one-cycle pulse on watchdog timeout.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- Reset: rst_n low forces state RESET, instret=0 and wait counter=0. In RESET every output is 0. RESET always goes to FETCH on the next edge.
- All outputs are decoded from the current state. Exceptions:
  - PCWrite in BRANCH also depends on Zero.
  - ImmSrc is decoded from op in every state.
- Outputs not listed for a state below are 0. ALUctrl codes: add=000.
- FETCH: mem_req=1, AdrSrc=0. On mem_ready:
  - IRWrite=1, PCWrite=1, ALUSrcA=00, ALUSrcB=10, ALUctrl=add, ResultSrc=10.
  - Next state DECODE.
  - Without mem_ready, stay in FETCH.
- DECODE: ALUSrcA=01, ALUSrcB=01, add (branch target). Next state by op:
  - 3 or 35 → MEMADR
  - 51 → EXECR
  - 19 → EXECI
  - 99 → BRANCH
  - 111 → JAL
  - other → illegal handling (see Optional Feature).
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. Next: MEMREAD if op==3, else MEMWRITE.
- MEMREAD: mem_req=1, AdrSrc=1. On mem_ready → MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Retire, → FETCH.
- MEMWRITE: mem_req=1, MemWrite=1, AdrSrc=1. On mem_ready: retire, → FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALU decode. → ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALU decode. → ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Retire, → FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUctrl=sub, ResultSrc=00.
  - PCWrite = Zero XOR funct3[0] (beq/bne).
  - Retire, → FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1. → ALUWB.
- ALU decode, by funct3:
  - 000 → sub(001) if op==51 and funct7_5, else add(000).
  - 111 → and(010).
  - 110 → or(011).
  - 010 → slt(101).
  - any other → add.
- Retire: instret increments by 1 on the retiring edge and wraps modulo 2^CNT_W.
- Watchdog:
  - The counter clears on entry to any mem_req state and increments each cycle mem_ready is low.
  - If it reaches MEM_TIMEOUT with mem_ready still low: mem_err=1 for that cycle, next state FETCH, no retire, PC unchanged, so the same instruction is refetched.
  - mem_ready high on the timeout cycle wins: normal completion, no mem_err.
- Async reset mid-access drops mem_req immediately. A mem_ready arriving during or after reset is ignored.

Optional Feature:
- Macro CTRL_ILLEGAL_TRAP_EN.
- When defined: an unknown opcode in DECODE → TRAP state. In TRAP:
  - all outputs 0, sticky output illegal=1;
  - leave only on reset.
- When undefined: an unknown opcode → FETCH, no retire (silent skip); no illegal port.

Decomposition:
- Package ctrl_pkg holds:
  - state_t enum;
  - ALU op codes (add, sub, and, or, slt);
  - ImmSrc codes;
  - opcode constants (3, 19, 35, 51, 99, 111);
  - ResultSrc and ALUSrc encodings.
- One combinational sub-module, alu_decoder: maps op, funct3 and funct7_5 to ALUctrl.

Test Plan:
- Reset and fetch: hold rst_n=0 → all outputs 0, instret=0. Release, mem_ready=1 → RESET, FETCH (IRWrite=PCWrite=1), DECODE.
- R-type sub: op=51, funct3=0, funct7_5=1 → EXECR with ALUctrl=001, then ALUWB with RegWrite=1; instret 0→1; 4 cycles total.
- lw with wait states: op=3, mem_ready low 3 cycles in MEMREAD → state held, mem_req=1, AdrSrc=1. Then ready → MEMWB with ResultSrc=01, RegWrite=1.
- bne/beq: funct3=001, Zero=0 → PCWrite=1. Same with Zero=1 → PCWrite=0. funct3=000, Zero=1 → PCWrite=1.
- Watchdog: MEM_TIMEOUT=4, mem_ready stuck low in FETCH → mem_err pulses on the 4th wait cycle, state FETCH, instret unchanged. Repeat with ready on the 4th cycle → no mem_err.
- Illegal op=0x7F:
  - with CTRL_ILLEGAL_TRAP_EN → TRAP, illegal=1 held until rst_n low;
  - without the macro → back to FETCH, instret unchanged.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_RESET,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_TRAP
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [6:0] OP_LOAD   = 7'd3;
    localparam logic [6:0] OP_IMM    = 7'd19;
    localparam logic [6:0] OP_STORE  = 7'd35;
    localparam logic [6:0] OP_R      = 7'd51;
    localparam logic [6:0] OP_BRANCH = 7'd99;
    localparam logic [6:0] OP_JAL    = 7'd111;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Immediate format implied by the opcode; R-type and unknown opcodes fall back to I.
    function automatic logic [1:0] imm_sel(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decode from opcode, funct3 and funct7[5].
module alu_decoder
    import ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W = 3
) (
    input  logic [6:0]            op,
    input  logic [2:0]            funct3,
    input  logic                  funct7_5,
    output logic [ALU_CTRL_W-1:0] alu_ctrl
);

    logic [2:0] code;

    // funct7[5] selects subtract only for register-register ops; addi ignores it.
    always_comb begin
        code = ALU_ADD;
        case (funct3)
            3'b000:  code = ((op == OP_R) && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b111:  code = ALU_AND;
            3'b110:  code = ALU_OR;
            3'b010:  code = ALU_SLT;
            default: code = ALU_ADD;
        endcase
    end

    assign alu_ctrl = ALU_CTRL_W'(code);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM with memory watchdog and retired-instruction counter.
// Define CTRL_ILLEGAL_TRAP_EN to trap on unknown opcodes (adds the illegal output).
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W  = 3,
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            op,
    input  logic [2:0]            funct3,
    input  logic                  funct7_5,
    input  logic                  Zero,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  MemWrite,
    output logic                  AdrSrc,
    output logic                  IRWrite,
    output logic                  PCWrite,
    output logic                  RegWrite,
    output logic [1:0]            ResultSrc,
    output logic [1:0]            ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic [ALU_CTRL_W-1:0] ALUctrl,
    output logic [1:0]            ImmSrc,
    output logic                  mem_err,
    output logic [CNT_W-1:0]      instret
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    output logic                  illegal
`endif
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_t              state;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [ALU_CTRL_W-1:0] alu_dec;
    logic                mem_state;
    logic                timeout;
    logic                retire;

    alu_decoder #(.ALU_CTRL_W(ALU_CTRL_W)) u_alu_decoder (
        .op       (op),
        .funct3   (funct3),
        .funct7_5 (funct7_5),
        .alu_ctrl (alu_dec)
    );

    assign mem_state = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
    assign timeout   = (MEM_TIMEOUT != 0) && mem_state && !mem_ready &&
                       (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));
    assign retire    = (state == S_MEMWB) || (state == S_ALUWB) || (state == S_BRANCH) ||
                       ((state == S_MEMWRITE) && mem_ready);
    assign mem_err   = timeout;

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign illegal = (state == S_TRAP);
`endif

    // The wait counter is zero on entry to any memory state because every exit clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_RESET;
            wait_cnt <= '0;
            instret  <= '0;
        end else begin
            wait_cnt <= (mem_state && !mem_ready && !timeout) ? wait_cnt + 1'b1 : '0;
            if (retire)
                instret <= instret + 1'b1;
            case (state)
                S_RESET:  state <= S_FETCH;
                S_FETCH:  if (mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_LOAD, OP_STORE: state <= S_MEMADR;
                        OP_R:              state <= S_EXECR;
                        OP_IMM:            state <= S_EXECI;
                        OP_BRANCH:         state <= S_BRANCH;
                        OP_JAL:            state <= S_JAL;
`ifdef CTRL_ILLEGAL_TRAP_EN
                        default:           state <= S_TRAP;
`else
                        default:           state <= S_FETCH;
`endif
                    endcase
                end
                S_MEMADR:   state <= (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD: begin
                    if (mem_ready)    state <= S_MEMWB;
                    else if (timeout) state <= S_FETCH;
                end
                S_MEMWB:    state <= S_FETCH;
                S_MEMWRITE: if (mem_ready || timeout) state <= S_FETCH;
                S_EXECR:    state <= S_ALUWB;
                S_EXECI:    state <= S_ALUWB;
                S_ALUWB:    state <= S_FETCH;
                S_BRANCH:   state <= S_FETCH;
                S_JAL:      state <= S_ALUWB;
                S_TRAP:     state <= S_TRAP;
                default:    state <= S_RESET;
            endcase
        end
    end

    // Fetch-stage strobes are qualified by mem_ready so a stalled fetch changes nothing.
    always_comb begin
        mem_req   = 1'b0;
        MemWrite  = 1'b0;
        AdrSrc    = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RS2;
        ALUctrl   = ALU_CTRL_W'(ALU_ADD);
        ImmSrc    = imm_sel(op);
        case (state)
            S_RESET, S_TRAP: ImmSrc = IMM_I;
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    IRWrite   = 1'b1;
                    PCWrite   = 1'b1;
                    ALUSrcA   = SRCA_PC;
                    ALUSrcB   = SRCB_FOUR;
                    ResultSrc = RES_ALU;
                end
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = RES_MEM;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req  = 1'b1;
                MemWrite = 1'b1;
                AdrSrc   = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_RS2;
                ALUctrl = alu_dec;
            end
            S_EXECI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                ALUctrl = alu_dec;
            end
            S_ALUWB:  RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_RS2;
                ALUctrl = ALU_CTRL_W'(ALU_SUB);
                PCWrite = Zero ^ funct3[0];
            end
            S_JAL: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
                PCWrite = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
